em_elastic_stage: RTL

- Parametrised, elastic successor to the fixed E→M pipeline register of the MIPS CPU.
- Carries the Execute-stage payload (Instr, PC, PC+8, ALUOut, RD2, A3, ExcCode, BD) to Memory under valid/ready handshake instead of a bare enable.
- A one-entry skid buffer lets the bus/DM side stall without a combinational ready path back into Execute.
- Keeps flush (bubble retaining PC/BD for macroscopic PC) and exception request (bubble carrying handler PC); adds a saturating stall-cycle counter.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_skid_entry.sv | 26 ++
 rtl/em_elastic_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: E->M payload struct, default widths and the exception handler PC shared by the elastic pipeline stage
package pipe_pkg;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_A3_W = 5;
  localparam int PIPE_EXC_W = 5;
  localparam int PIPE_CNT_W = 16;
  localparam logic [PIPE_DATA_W-1:0] PIPE_HANDLER_PC = 32'h0000_4180;
  typedef struct packed {
    logic [PIPE_DATA_W-1:0] instr;
    logic [PIPE_DATA_W-1:0] pc;
    logic [PIPE_DATA_W-1:0] pcplus8;
    logic [PIPE_DATA_W-1:0] aluout;
    logic [PIPE_DATA_W-1:0] rd2;
    logic [PIPE_A3_W-1:0] a3;
    logic [PIPE_EXC_W-1:0] exccode;
    logic bd;
  } em_payload_t;
endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: one-entry payload+valid register; clk/reset, load/clear (clear wins), d in, valid/q out
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter type T = em_payload_t
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  T     d,
  output logic valid,
  output T     q
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      q <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q <= d;
    end
  end
endmodule

// File: rtl/em_elastic_stage.sv
// em_elastic_stage: elastic E->M register with skid buffer, flush/req bubbles and saturating stall counter; in_* handshake+payload, out_* handshake+payload, stall_cycles
module em_elastic_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int A3_W = PIPE_A3_W,
  parameter int EXC_W = PIPE_EXC_W,
  parameter logic [DATA_W-1:0] HANDLER_PC = PIPE_HANDLER_PC,
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_pcplus8,
  input  logic [DATA_W-1:0] in_aluout,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [A3_W-1:0]   in_a3,
  input  logic [EXC_W-1:0]  in_exccode,
  input  logic              in_bd,
  input  logic              flush,
  input  logic              req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_pcplus8,
  output logic [DATA_W-1:0] out_aluout,
  output logic [DATA_W-1:0] out_rd2,
  output logic [A3_W-1:0]   out_a3,
  output logic [EXC_W-1:0]  out_exccode,
  output logic              out_bd,
  output logic [CNT_W-1:0]  stall_cycles
);
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pcplus8;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] rd2;
    logic [A3_W-1:0] a3;
    logic [EXC_W-1:0] exccode;
    logic bd;
  } payload_t;
  payload_t in_p, out_p, skid_p, bubble_p;
  logic skid_valid, load, accept;
  assign in_p = '{in_instr, in_pc, in_pcplus8, in_aluout, in_rd2, in_a3, in_exccode, in_bd};
  assign in_ready = !skid_valid;
  assign load = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  always_comb begin
    bubble_p = '0;
    bubble_p.pc = req ? HANDLER_PC : flush ? in_pc : out_p.pc;
    bubble_p.bd = !req && (flush ? in_bd : out_p.bd);
  end
  pipe_skid_entry #(.T(payload_t)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (accept && (!load || skid_valid)),
    .clear (req || flush || (load && skid_valid && !accept)),
    .d     (in_p),
    .valid (skid_valid),
    .q     (skid_p)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_p <= '0;
    end else if (req || flush) begin
      out_valid <= 1'b0;
      out_p <= bubble_p;
    end else if (load) begin
      out_valid <= skid_valid || accept;
      out_p <= skid_valid ? skid_p : accept ? in_p : bubble_p;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) stall_cycles <= '0;
    else if (out_valid && !out_ready && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
  end
  assign out_instr = out_p.instr;
  assign out_pc = out_p.pc;
  assign out_pcplus8 = out_p.pcplus8;
  assign out_aluout = out_p.aluout;
  assign out_rd2 = out_p.rd2;
  assign out_a3 = out_p.a3;
  assign out_exccode = out_p.exccode;
  assign out_bd = out_p.bd;
endmodule
